// File: rtl/box_drawer.sv
`default_nettype none
// ============================================================================
//  Module   : box_drawer
//  Purpose  : Redraws a square sprite on a VGA frame buffer each time its row
//             changes. On a game tick the old box is erased with the
//             background colour and then drawn at the new row, one pixel per
//             clk, in row-major order. Rows at or past SCREEN_H are clipped:
//             they still take their cycle but issue no write strobe.
//  Ports    : clk          - system clock, rising edge
//             resetn       - asynchronous active-low reset
//             game_tick    - one-clk pulse per game tick
//             y_coordinate - current box top row (7 bits)
//             vga_x        - pixel column (8 bits, registered)
//             vga_y        - pixel row (7 bits, registered)
//             vga_colour   - pixel colour (3 bits, registered)
//             vga_plot     - pixel write strobe (registered)
//             busy         - high while a redraw is in progress (registered)
//  Revision : 1.0 - initial release
// ============================================================================
module box_drawer #(
  parameter logic [7:0] BOX_X      = 8'd20,
  parameter int         BOX_SIZE   = 4,
  parameter logic [2:0] BOX_COLOUR = 3'b110,
  parameter logic [2:0] BG_COLOUR  = 3'b000,
  parameter logic [6:0] SCREEN_H   = 7'd120
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       game_tick,
  input  logic [6:0] y_coordinate,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy
);

  // Index of the last column/row inside the box.
  localparam logic [2:0] c_LAST = 3'(BOX_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ERASE = 2'd1,
    S_DRAW  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  // The pixel counter p is kept split as (row, col) so that p / BOX_SIZE and
  // p mod BOX_SIZE never need a divider.
  logic [2:0] col_q, col_d;
  logic [2:0] row_q, row_d;
  logic       pending_q, pending_d;
  logic       drawn_valid_q, drawn_valid_d;
  logic [6:0] drawn_y_q, drawn_y_d;
  logic [6:0] new_y_q, new_y_d;
  logic [7:0] vga_x_q, vga_x_d;
  logic [6:0] vga_y_q, vga_y_d;
  logic [2:0] vga_colour_q, vga_colour_d;
  logic       vga_plot_q, vga_plot_d;
  logic       busy_q, busy_d;

  logic [6:0] w_base;
  logic [7:0] w_row_sum;
  logic       w_last;

  // Erase scans the previously drawn position, draw scans the new one.
  assign w_base    = (state_q == S_ERASE) ? drawn_y_q : new_y_q;
  // Eight bits wide so a box near the bottom cannot wrap back to row 0.
  assign w_row_sum = {1'b0, w_base} + {5'b0, row_q};
  assign w_last    = (col_q == c_LAST) && (row_q == c_LAST);

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    pending_d     = pending_q;
    drawn_valid_d = drawn_valid_q;
    drawn_y_d     = drawn_y_q;
    new_y_d       = new_y_q;
    vga_x_d       = vga_x_q;
    vga_y_d       = vga_y_q;
    vga_colour_d  = vga_colour_q;
    vga_plot_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (game_tick || pending_q) begin
          new_y_d   = y_coordinate;
          pending_d = 1'b0;
          col_d     = 3'd0;
          row_d     = 3'd0;
          if (!drawn_valid_q) begin
            state_d = S_DRAW;
          end else if (y_coordinate != drawn_y_q) begin
            state_d = S_ERASE;
          end
          // Box already shown at this row: nothing to redraw.
        end
      end

      S_ERASE, S_DRAW: begin
        if (game_tick) begin
          pending_d = 1'b1;
        end
        vga_x_d      = BOX_X + {5'b0, col_q};
        vga_y_d      = w_row_sum[6:0];
        vga_colour_d = (state_q == S_ERASE) ? BG_COLOUR : BOX_COLOUR;
        vga_plot_d   = (w_row_sum < {1'b0, SCREEN_H});

        if (w_last) begin
          col_d   = 3'd0;
          row_d   = 3'd0;
          state_d = (state_q == S_ERASE) ? S_DRAW : S_DONE;
        end else if (col_q == c_LAST) begin
          col_d = 3'd0;
          row_d = row_q + 3'd1;
        end else begin
          col_d = col_q + 3'd1;
        end
      end

      S_DONE: begin
        if (game_tick) begin
          pending_d = 1'b1;
        end
        drawn_y_d     = new_y_q;
        drawn_valid_d = 1'b1;
        state_d       = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      col_q         <= 3'd0;
      row_q         <= 3'd0;
      pending_q     <= 1'b0;
      drawn_valid_q <= 1'b0;
      drawn_y_q     <= 7'd0;
      new_y_q       <= 7'd0;
      vga_x_q       <= 8'd0;
      vga_y_q       <= 7'd0;
      vga_colour_q  <= 3'd0;
      vga_plot_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      pending_q     <= pending_d;
      drawn_valid_q <= drawn_valid_d;
      drawn_y_q     <= drawn_y_d;
      new_y_q       <= new_y_d;
      vga_x_q       <= vga_x_d;
      vga_y_q       <= vga_y_d;
      vga_colour_q  <= vga_colour_d;
      vga_plot_q    <= vga_plot_d;
      busy_q        <= busy_d;
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire
